// File: rtl/dtw_stream_core.sv
// dtw_stream_core: streaming subsequence dynamic-time-warping engine.
// A query of up to QRY_MAX samples is held in a local memory. Each accepted
// reference sample adds one DTW column, evaluated one cell per cycle. The
// block tracks the best final-row cost, where it occurred, and whether that
// cost ever reached the threshold.
module dtw_stream_core #(
  parameter int width   = 16,
  parameter int QRY_MAX = 256,
  parameter int POS_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       q_we,
  input  logic [$clog2(QRY_MAX)-1:0] q_addr,
  input  logic [width-1:0]           q_data,
  input  logic [$clog2(QRY_MAX):0]   qlen,
  input  logic [width-1:0]           thresh,
  input  logic                       start,
  input  logic                       ref_valid,
  output logic                       ref_ready,
  input  logic [width-1:0]           ref_data,
  input  logic                       ref_last,
  output logic [width-1:0]           DTW_minval,
  output logic [POS_W-1:0]           position,
  output logic                       done,
  output logic                       hit,
  output logic                       err
);

  localparam int AW = $clog2(QRY_MAX);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_REF, COMPUTE, DONE} state_t;

  state_t           state, state_nxt;
  logic [width-1:0] q_mem [QRY_MAX];
  logic [width-1:0] col   [QRY_MAX];
  logic [AW-1:0]    row;
  logic [POS_W-1:0] j;
  logic [width-1:0] r_lat;
  logic             last_lat;
  logic [LW-1:0]    qlen_r;
  logic [width-1:0] thresh_r;
  logic [width-1:0] up_r;
  logic [width-1:0] diag_r;

  logic             idle_like, qlen_ok, start_ok, start_bad, accept, last_row;
  logic [width-1:0] q_i, left, cost, best_prev, d_cell;
  logic [width:0]   sum;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign qlen_ok   = (qlen != '0) && (qlen <= LW'(QRY_MAX));
  assign start_ok  = start && idle_like && qlen_ok;
  assign start_bad = start && idle_like && !qlen_ok;
  assign accept    = ref_valid && ref_ready;
  assign last_row  = (LW'(row) + LW'(1)) == qlen_r;
  assign q_i       = q_mem[row];
  assign left      = col[row];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start_ok)  state_nxt = WAIT_REF;
      WAIT_REF:   if (ref_valid) state_nxt = COMPUTE;
      COMPUTE:    if (last_row)  state_nxt = last_lat ? DONE : WAIT_REF;
      default:                   state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    ref_ready = (state == WAIT_REF);
    done      = (state == DONE);
  end

  // One DTW cell: cost plus the smallest in-matrix neighbour, saturated.
  always_comb begin
    cost      = (q_i >= r_lat) ? (q_i - r_lat) : (r_lat - q_i);
    best_prev = up_r;
    if (j != '0) begin
      if (left   < best_prev) best_prev = left;
      if (diag_r < best_prev) best_prev = diag_r;
    end
    sum = {1'b0, cost} + {1'b0, best_prev};
    if (row == '0)    d_cell = cost;
    else if (sum[width]) d_cell = '1;
    else                 d_cell = sum[width-1:0];
  end

  // Run control, column walk and result tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row        <= '0;
      j          <= '0;
      r_lat      <= '0;
      last_lat   <= 1'b0;
      qlen_r     <= '0;
      thresh_r   <= '0;
      up_r       <= '0;
      diag_r     <= '0;
      DTW_minval <= '1;
      position   <= '0;
      hit        <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees pre-edge values.
      err <= start_bad;
      if (start_ok) begin
        qlen_r     <= qlen;
        thresh_r   <= thresh;
        hit        <= 1'b0;
        DTW_minval <= '1;
        position   <= '0;
        j          <= '0;
      end
      if (accept) begin
        r_lat    <= ref_data;
        last_lat <= ref_last;
        row      <= '0;
      end
      if (state == COMPUTE) begin
        up_r   <= d_cell;
        diag_r <= left;   // old D(row, j-1) becomes the diagonal for row+1
        if (last_row) begin
          if (d_cell < DTW_minval) begin
            DTW_minval <= d_cell;
            position   <= j;
          end
          if (d_cell <= thresh_r) hit <= 1'b1;
          j <= j + POS_W'(1);
        end else begin
          row <= row + AW'(1);
        end
      end
    end
  end

  // Query memory and in-place previous-column buffer.
  // NOTE: memories carry no reset; column j=0 never reads the buffer, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (q_we && idle_like && (int'(q_addr) < QRY_MAX)) q_mem[q_addr] <= q_data;
    if (state == COMPUTE) col[row] <= d_cell;
  end

endmodule

// File: tb/tb_dtw_stream_core.sv
// Bench for dtw_stream_core: a 16-bit and an 8-bit instance share stimulus.
// A matrix-level DTW model gives per-column expectations; one negedge
// process compares every output; literal values pin the directed cases.
module tb_dtw_stream_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        q_we = 1'b0;
  logic [2:0]  q_addr = '0;
  logic [15:0] q_data = '0;
  logic [3:0]  qlen = '0;
  logic [15:0] thresh = '0;
  logic        start = 1'b0;
  logic        ref_valid = 1'b0;
  logic [15:0] ref_data = '0;
  logic        ref_last = 1'b0;

  logic        ready16, done16, hit16, err16;
  logic [15:0] min16;
  logic [31:0] pos16;
  logic        ready8, done8, hit8, err8;
  logic [7:0]  min8;
  logic [31:0] pos8;

  dtw_stream_core #(.width(16), .QRY_MAX(8), .POS_W(32)) dut16 (
    .clk(clk), .rst(rst), .q_we(q_we), .q_addr(q_addr), .q_data(q_data),
    .qlen(qlen), .thresh(thresh), .start(start), .ref_valid(ref_valid),
    .ref_ready(ready16), .ref_data(ref_data), .ref_last(ref_last),
    .DTW_minval(min16), .position(pos16), .done(done16), .hit(hit16), .err(err16)
  );

  dtw_stream_core #(.width(8), .QRY_MAX(8), .POS_W(32)) dut8 (
    .clk(clk), .rst(rst), .q_we(q_we), .q_addr(q_addr), .q_data(q_data[7:0]),
    .qlen(qlen), .thresh(thresh[7:0]), .start(start), .ref_valid(ref_valid),
    .ref_ready(ready8), .ref_data(ref_data[7:0]), .ref_last(ref_last),
    .DTW_minval(min8), .position(pos8), .done(done8), .hit(hit8), .err(err8)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int qv [8];
  int rv [8];
  int nq, nr;

  bit mon_en = 1'b0;
  int exp_min16, exp_pos16, exp_min8, exp_pos8;
  bit exp_hit16, exp_hit8, exp_ready, exp_done, exp_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Final-row value of column k from the full subsequence DTW matrix.
  function automatic int model_final(input int w, input int k);
    int sat;
    int d [8][8];
    int c, m, a, b;
    sat = (1 << w) - 1;
    for (int jj = 0; jj <= k; jj++) begin
      for (int i = 0; i < nq; i++) begin
        a = qv[i] & sat;
        b = rv[jj] & sat;
        c = (a > b) ? a - b : b - a;
        if (i == 0) begin
          d[i][jj] = c;
        end else begin
          m = d[i-1][jj];
          if (jj > 0) begin
            if (d[i][jj-1] < m)   m = d[i][jj-1];
            if (d[i-1][jj-1] < m) m = d[i-1][jj-1];
          end
          d[i][jj] = (c + m > sat) ? sat : c + m;
        end
      end
    end
    return d[nq-1][k];
  endfunction

  task automatic set_exp_cleared(input bit ready);
    exp_min16 = 65535; exp_pos16 = 0; exp_hit16 = 1'b0;
    exp_min8  = 255;   exp_pos8  = 0; exp_hit8  = 1'b0;
    exp_ready = ready; exp_done  = 1'b0; exp_err = 1'b0;
  endtask

  task automatic col_done(input int k, input int thr, input bit last);
    int f;
    f = model_final(16, k);
    if (f < exp_min16) begin exp_min16 = f; exp_pos16 = k; end
    if (f <= thr) exp_hit16 = 1'b1;
    f = model_final(8, k);
    if (f < exp_min8) begin exp_min8 = f; exp_pos8 = k; end
    if (f <= (thr & 255)) exp_hit8 = 1'b1;
    exp_ready = !last;
    exp_done  = last;
  endtask

  // Compare process: every output of both instances on every falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready16", 64'(ready16), 64'(exp_ready));
      check("done16",  64'(done16),  64'(exp_done));
      check("err16",   64'(err16),   64'(exp_err));
      check("min16",   64'(min16),   64'(exp_min16));
      check("pos16",   64'(pos16),   64'(exp_pos16));
      check("hit16",   64'(hit16),   64'(exp_hit16));
      check("ready8",  64'(ready8),  64'(exp_ready));
      check("done8",   64'(done8),   64'(exp_done));
      check("err8",    64'(err8),    64'(exp_err));
      check("min8",    64'(min8),    64'(exp_min8));
      check("pos8",    64'(pos8),    64'(exp_pos8));
      check("hit8",    64'(hit8),    64'(exp_hit8));
    end
  end

  task automatic write_query();
    for (int k = 0; k < nq; k++) begin
      q_we = 1'b1; q_addr = 3'(k); q_data = 16'(qv[k]);
      tick();
    end
    q_we = 1'b0;
  endtask

  task automatic do_start(input int thr);
    qlen = 4'(nq); thresh = 16'(thr); start = 1'b1;
    tick();
    start = 1'b0;
    set_exp_cleared(1'b1);
  endtask

  // One reference sample: accepted on the next edge, then nq compute cycles.
  task automatic feed(input int k, input int thr);
    ref_valid = 1'b1; ref_data = 16'(rv[k]); ref_last = (k == nr - 1);
    tick();
    ref_valid = 1'b0; ref_last = 1'b0;
    exp_ready = 1'b0;
    for (int t = 0; t < nq; t++) tick();
    col_done(k, thr, k == nr - 1);
  endtask

  task automatic do_run(input int thr, input bit write_q, input bit poke);
    if (write_q) write_query();
    do_start(thr);
    if (poke) begin
      // Start and query writes while waiting for reference data are ignored.
      q_we = 1'b1; q_addr = 3'd0; q_data = 16'd100;
      start = 1'b1; qlen = 4'd0;
      tick();
      q_we = 1'b0; start = 1'b0;
    end
    for (int k = 0; k < nr; k++) feed(k, thr);
  endtask

  task automatic load_exact();
    nq = 3; qv[0] = 1; qv[1] = 2; qv[2] = 3;
    nr = 5; rv[0] = 5; rv[1] = 1; rv[2] = 2; rv[3] = 3; rv[4] = 9;
  endtask

  task automatic check_exact(input string tag);
    check({tag, "_done"},  64'(done16), 64'd1);
    check({tag, "_min16"}, 64'(min16),  64'd0);
    check({tag, "_pos16"}, 64'(pos16),  64'd3);
    check({tag, "_hit16"}, 64'(hit16),  64'd1);
    check({tag, "_min8"},  64'(min8),   64'd0);
    check({tag, "_pos8"},  64'(pos8),   64'd3);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_exp_cleared(1'b0);
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Bad starts: qlen=0 and qlen>QRY_MAX pulse err, state stays IDLE.
    ref_valid = 1'b1; ref_data = 16'd5;
    qlen = 4'd0; start = 1'b1;
    tick();
    start = 1'b0; exp_err = 1'b1;
    tick();
    exp_err = 1'b0;
    qlen = 4'd9; start = 1'b1;
    tick();
    start = 1'b0; exp_err = 1'b1;
    tick();
    exp_err = 1'b0;
    tick();
    ref_valid = 1'b0;
    check("bad_start_ready", 64'(ready16), 64'd0);

    // Exact match, thresh=0, with ignored start/write in WAIT_REF.
    load_exact();
    do_run(0, 1'b1, 1'b1);
    check_exact("exact");

    // Tie: earliest position wins.
    nq = 1; qv[0] = 4;
    nr = 3; rv[0] = 4; rv[1] = 7; rv[2] = 4;
    do_run(0, 1'b1, 1'b0);
    check("tie_min16", 64'(min16), 64'd0);
    check("tie_pos16", 64'(pos16), 64'd0);
    check("tie_pos8",  64'(pos8),  64'd0);

    // Saturation: 255+255 clips at 255 on the 8-bit instance.
    nq = 2; qv[0] = 255; qv[1] = 255;
    nr = 1; rv[0] = 0;
    do_run(0, 1'b1, 1'b0);
    check("sat_min8",  64'(min8),  64'd255);
    check("sat_pos8",  64'(pos8),  64'd0);
    check("sat_min16", 64'(min16), 64'd510);
    check("sat_hit8",  64'(hit8),  64'd0);

    // Threshold not met.
    nq = 3; qv[0] = 9; qv[1] = 9; qv[2] = 9;
    nr = 4; rv[0] = 5; rv[1] = 1; rv[2] = 2; rv[3] = 3;
    do_run(2, 1'b1, 1'b0);
    check("thr_hit16", 64'(hit16), 64'd0);
    check("thr_hit8",  64'(hit8),  64'd0);
    check("thr_min16", 64'(min16), 64'd12);
    check("thr_done",  64'(done16), 64'd1);

    // Reset in the middle of a column.
    load_exact();
    write_query();
    do_start(0);
    feed(0, 0);
    ref_valid = 1'b1; ref_data = 16'(rv[1]);
    tick();
    ref_valid = 1'b0;
    exp_ready = 1'b0;
    tick();
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_ready", 64'(ready16), 64'd0);
    check("rst_done",  64'(done16),  64'd0);
    check("rst_hit",   64'(hit16),   64'd0);
    check("rst_err",   64'(err16),   64'd0);
    check("rst_min16", 64'(min16),   64'hFFFF);
    check("rst_pos16", 64'(pos16),   64'd0);
    check("rst_min8",  64'(min8),    64'hFF);
    tick();
    tick();
    rst = 1'b0;
    set_exp_cleared(1'b0);
    mon_en = 1'b1;

    // No sample is taken without a fresh start.
    ref_valid = 1'b1; ref_data = 16'd5;
    repeat (3) tick();
    ref_valid = 1'b0;

    // Rerun with the retained query memory.
    do_run(0, 1'b0, 1'b0);
    check_exact("rerun");

    tick();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
